// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: parametrised ALU stage with valid/ready handshakes on both sides.
// Single-cycle ops complete in one registered cycle; MUL is an iterative
// shift-add multiplier taking WIDTH cycles plus one DONE cycle.
// Optional build macro: ALU_SAT_EN (saturating ADD/SUB/MUL results).
module alu_pipe_hs #(
   parameter  int WIDTH   = 16,
   localparam int SHIFT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   input1,
   input  logic [WIDTH-1:0]   input2,
   input  logic [SHIFT_W-1:0] shiftValue,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               carryFlag,
   output logic               busy
);

`ifdef ALU_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_SGE  = 4'd3;
   localparam logic [3:0] OP_XNOR = 4'd4;
   localparam logic [3:0] OP_SEQ  = 4'd5;
   localparam logic [3:0] OP_MAX  = 4'd6;
   localparam logic [3:0] OP_MIN  = 4'd7;
   localparam logic [3:0] OP_NAND = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SLL  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

   state_t               state_q, state_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q, busy_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 carry_q, carry_d;
   logic [WIDTH-1:0]     mul_a_q, mul_a_d;
   logic [WIDTH-1:0]     mul_b_q, mul_b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [SHIFT_W-1:0]   cnt_q, cnt_d;
   logic                 accept;
   logic                 fire;
   logic [WIDTH:0]       alu_out;

   // Replace an overflowed result by its saturation value in the saturating build.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] res,
                                                 input logic             ovf,
                                                 input logic [WIDTH-1:0] sat_val);
      if (SAT_EN && ovf) return sat_val;
      return res;
   endfunction

   // All single-cycle operations; returns {carry, result}.
   function automatic logic [WIDTH:0] alu_single(input logic [3:0]         op,
                                                 input logic [WIDTH-1:0]   a,
                                                 input logic [WIDTH-1:0]   b,
                                                 input logic [SHIFT_W-1:0] sh);
      logic [WIDTH:0]          wide;
      logic signed [WIDTH-1:0] a_s;
      logic signed [WIDTH-1:0] b_s;
      logic [WIDTH-1:0]        res;
      logic                    cy;
      wide = '0;
      a_s  = a;
      b_s  = b;
      res  = '0;
      cy   = 1'b0;
      case (op)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            cy   = wide[WIDTH];
            res  = saturate(wide[WIDTH-1:0], cy, '1);
         end
         OP_SUB: begin
            wide = {1'b0, a} - {1'b0, b};
            cy   = wide[WIDTH];
            res  = saturate(wide[WIDTH-1:0], cy, '0);
         end
         OP_SGE:  res = {{(WIDTH-1){1'b0}}, (a_s >= b_s)};
         OP_XNOR: res = ~(a ^ b);
         OP_SEQ:  res = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_MAX:  res = (a > b) ? a : b;
         OP_MIN:  res = (a < b) ? a : b;
         OP_NAND: res = ~(a & b);
         OP_SRL:  res = a >> sh;
         OP_SLL:  res = a << sh;
         OP_SRA:  res = a_s >>> sh;
         default: res = '0;
      endcase
      return {cy, res};
   endfunction

   assign accept    = in_valid && in_ready;
   assign fire      = out_valid_q && out_ready;
   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign alu_out   = alu_single(opcode, input1, input2, shiftValue);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carryFlag = carry_q;
   assign busy      = busy_q;

   // Next-state, handshake and multiplier-iteration logic.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      result_d    = result_q;
      carry_d     = carry_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (fire) out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (opcode == OP_MUL) begin
                  mul_a_d = input1;
                  mul_b_d = input2;
                  acc_d   = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = MULT;
               end else begin
                  result_d    = alu_out[WIDTH-1:0];
                  carry_d     = alu_out[WIDTH];
                  out_valid_d = 1'b1;
               end
            end
         end
         MULT: begin
            if (mul_b_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, mul_a_q} << cnt_q);
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == SHIFT_W'(WIDTH - 1)) state_d = DONE;
         end
         DONE: begin
            if (!out_valid_q || out_ready) begin
               carry_d     = |acc_q[2*WIDTH-1:WIDTH];
               result_d    = saturate(acc_q[WIDTH-1:0], carry_d, '1);
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
      end
   end

   // Multiplier datapath; always re-initialised on a MUL accept, so no reset needed.
   always_ff @(posedge clk) begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
   end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Testbench for alu_pipe_hs (WIDTH=16): directed cases plus randomized traffic,
// checked by a scoreboard against a behavioural model.
`timescale 1ns/1ps
module tb_alu_pipe_hs;
   localparam int W = 16;
   localparam longint MAXV = (longint'(1) << W) - 1;
`ifdef ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   opcode = '0;
   logic [W-1:0] input1 = '0;
   logic [W-1:0] input2 = '0;
   logic [3:0]   shiftValue = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         carryFlag;
   logic         busy;

   alu_pipe_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carryFlag(carryFlag), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         cy;
      int           due;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   rand_ready = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural reference: plain integer arithmetic on the operand values.
   function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [3:0] sh);
      longint ua, ub, sa, sb, p, r;
      bit c;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[W-1] ? ua - (MAXV + 1) : ua;
      sb = b[W-1] ? ub - (MAXV + 1) : ub;
      r = 0;
      c = 1'b0;
      case (op)
         4'd0: begin p = ua + ub; c = (p > MAXV); r = p; if (SAT && c) r = MAXV; end
         4'd1: begin c = (ua < ub); r = ua - ub; if (SAT && c) r = 0; end
         4'd2: begin p = ua * ub; c = (p > MAXV); r = p; if (SAT && c) r = MAXV; end
         4'd3: r = (sa >= sb) ? 1 : 0;
         4'd4: r = ~(ua ^ ub);
         4'd5: r = (ua == ub) ? 1 : 0;
         4'd6: r = (ua > ub) ? ua : ub;
         4'd7: r = (ua < ub) ? ua : ub;
         4'd8: r = ~(ua & ub);
         4'd9: r = ua >> sh;
         4'd10: r = ua << sh;
         4'd11: r = sa >>> sh;
         default: r = 0;
      endcase
      return {c, r[W-1:0]};
   endfunction

   // Present one bundle and hold it until accepted; record the expected response.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sh);
      int t;
      exp_t e;
      logic [W:0] m;
      opcode = op; input1 = a; input2 = b; shiftValue = sh; in_valid = 1'b1;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready) begin
            m = model(op, a, b, sh);
            e.res = m[W-1:0];
            e.cy  = m[W];
            e.due = cyc + ((op == 4'd2) ? W + 2 : 1);
            sbq.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         t++;
         if (t > 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: op %0d never accepted in %0d cycles", op, t);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   // Random backpressure during the randomized phase.
   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compare each newly presented result, and stability while held.
   bit           prev_v = 1'b0;
   bit           prev_r = 1'b0;
   logic [W-1:0] prev_res = '0;
   logic         prev_cy = 1'b0;
   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (out_valid) begin
            if (prev_v && !prev_r) begin
               chk("hold_result", 32'(result), 32'(prev_res));
               chk("hold_carry", 32'(carryFlag), 32'(prev_cy));
            end else if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: result 0x%0h with no pending request", result);
            end else begin
               chk("result", 32'(result), 32'(sbq[0].res));
               chk("carry", 32'(carryFlag), 32'(sbq[0].cy));
               chk("latency", 32'(cyc), 32'(sbq[0].due));
            end
            if (out_ready && sbq.size() > 0) void'(sbq.pop_front());
         end
         prev_v   = out_valid;
         prev_r   = out_ready;
         prev_res = result;
         prev_cy  = carryFlag;
      end else begin
         prev_v = 1'b0;
      end
   end

   initial begin
      int t;
      logic [W-1:0] a, b;
      logic [W-1:0] corners [4];
      corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000; corners[3] = 16'h7FFF;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_result", 32'(result), 0);
      chk("reset_carry", 32'(carryFlag), 0);
      mon_en = 1'b1;

      send(4'd0, 16'hFFFF, 16'h0001, 4'd0);
      send(4'd1, 16'h0003, 16'h0005, 4'd0);
      send(4'd3, 16'h8000, 16'h0001, 4'd0);

      send(4'd2, 16'h0100, 16'h0100, 4'd0);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         chk("mul_busy", 32'(busy), 1);
         chk("mul_in_ready", 32'(in_ready), 0);
      end
      @(negedge clk);
      chk("mul_busy_clear", 32'(busy), 0);
      chk("mul_out_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      send(4'd2, 16'h0003, 16'h0005, 4'd0);

      send(4'd4, 16'h00F0, 16'h0F00, 4'd0);
      send(4'd8, 16'h00F0, 16'h0F00, 4'd0);
      send(4'd6, 16'h00F0, 16'h0F00, 4'd0);
      send(4'd7, 16'h00F0, 16'h0F00, 4'd0);
      repeat (3) @(posedge clk);
      #1;

      out_ready = 1'b0;
      send(4'd0, 16'h0001, 16'h0002, 4'd0);
      fork
         send(4'd11, 16'h8000, 16'h0000, 4'd15);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("bp_in_ready", 32'(in_ready), 0);
               chk("bp_out_valid", 32'(out_valid), 1);
               chk("bp_result", 32'(result), 32'h0003);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;

      send(4'd2, 16'h1234, 16'h5678, 4'd0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_result", 32'(result), 0);
      repeat (25) @(posedge clk);
      #1;

      send(4'd12, 16'h1111, 16'h2222, 4'd3);
      send(4'd15, 16'hFFFF, 16'hFFFF, 4'd7);

      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
         b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
         send(4'($urandom_range(0, 15)), a, b, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (sbq.size() > 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("drain_pending", 32'(sbq.size()), 0);
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
